// File: rtl/pcie_phy_pkg.sv
// Shared Gen3 PHY types and symbol constants.
// Used by the receive-path block classifier.
package pcie_phy_pkg;

    typedef enum logic [1:0] {
        RATE_GEN1 = 2'd0,
        RATE_GEN2 = 2'd1,
        RATE_GEN3 = 2'd2,
        RATE_GEN4 = 2'd3
    } rate_speed_e;

    typedef enum logic [2:0] {
        OS_TS1     = 3'd0,
        OS_TS2     = 3'd1,
        OS_SKP     = 3'd2,
        OS_EIEOS   = 3'd3,
        OS_EIOS    = 3'd4,
        OS_SDS     = 3'd5,
        OS_UNKNOWN = 3'd6
    } os_type_e;

    localparam logic [7:0] GEN3_TS1_ID   = 8'h1E;
    localparam logic [7:0] GEN3_TS2_ID   = 8'h2D;
    localparam logic [7:0] GEN3_SKP      = 8'hAA;
    localparam logic [7:0] GEN3_SKP_END  = 8'hE1;
    localparam logic [7:0] GEN3_EIOS_ID  = 8'h66;
    localparam logic [7:0] GEN3_EIEOS_ID = 8'h00;
    localparam logic [7:0] GEN3_SDS_ID   = 8'hE1;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;

endpackage

// File: rtl/rx_block_classifier_if.sv
// Descrambled lane word stream entering the block classifier.
// No backpressure: the consumer always accepts.
interface rx_block_classifier_if;
    logic [31:0] data_in_i;
    logic        data_valid_i;
    logic        block_start_i;
    logic [1:0]  sync_header_i;

    modport master (
        output data_in_i,
        output data_valid_i,
        output block_start_i,
        output sync_header_i
    );

    modport slave (
        input data_in_i,
        input data_valid_i,
        input block_start_i,
        input sync_header_i
    );
endinterface

// File: rtl/rx_block_classifier.sv
// Gen3 128b/130b block tracker: forwards data blocks, assembles
// ordered sets and flags framing errors.
module rx_block_classifier
    import pcie_phy_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  rate_speed_e           curr_data_rate_i,
    rx_block_classifier_if.slave  rx,
    output logic [31:0]           data_o,
    output logic                  data_valid_o,
    output logic                  data_blk_start_o,
    output logic                  os_valid_o,
    output os_type_e              os_type_o,
    output logic [127:0]          os_data_o,
    output logic [4:0]            os_skp_len_o,
    output logic                  block_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_BLK = 2'd1,
        OS_BLK   = 2'd2,
        SKP_BLK  = 2'd3
    } blk_state_e;

    function automatic os_type_e classify_os(input logic [7:0] sym);
        os_type_e t;
        t = OS_UNKNOWN;
        if (sym == GEN3_TS1_ID)        t = OS_TS1;
        else if (sym == GEN3_TS2_ID)   t = OS_TS2;
        else if (sym == GEN3_EIEOS_ID) t = OS_EIEOS;
        else if (sym == GEN3_EIOS_ID)  t = OS_EIOS;
        else if (sym == GEN3_SDS_ID)   t = OS_SDS;
        return t;
    endfunction

    blk_state_e   state_q, state_d;
    logic [2:0]   wcnt_q, wcnt_d;
    logic [127:0] osbuf_q, osbuf_d;
    os_type_e     pend_type_q, pend_type_d;
    logic [31:0]  data_q, data_d;
    logic         data_valid_q, data_valid_d;
    logic         blk_start_q, blk_start_d;
    logic         os_valid_q, os_valid_d;
    os_type_e     os_type_q, os_type_d;
    logic [127:0] os_data_q, os_data_d;
    logic [4:0]   skp_len_q, skp_len_d;
    logic         err_q, err_d;

    logic         active;
    logic [7:0]   sym0;
    logic [31:0]  word;
    logic [1:0]   slot;

    assign active = (curr_data_rate_i >= RATE_GEN3);
    assign word   = rx.data_in_i;
    assign sym0   = rx.data_in_i[7:0];
    assign slot   = wcnt_q[1:0];

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        osbuf_d      = osbuf_q;
        pend_type_d  = pend_type_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        blk_start_d  = 1'b0;
        os_valid_d   = 1'b0;
        os_type_d    = os_type_q;
        os_data_d    = os_data_q;
        skp_len_d    = skp_len_q;
        err_d        = 1'b0;

        if (!active) begin
            state_d = IDLE;
            wcnt_d  = 3'd0;
        end else if (rx.data_valid_i) begin
            if (rx.block_start_i) begin
                // A start mid-block drops the partial block but still opens a new one
                if (wcnt_q != 3'd0) err_d = 1'b1;
                if (rx.sync_header_i == SYNC_DATA) begin
                    state_d      = DATA_BLK;
                    wcnt_d       = 3'd1;
                    data_d       = word;
                    data_valid_d = 1'b1;
                    blk_start_d  = 1'b1;
                end else if (rx.sync_header_i == SYNC_OS) begin
                    wcnt_d  = 3'd1;
                    osbuf_d = {96'd0, word};
                    if (sym0 == GEN3_SKP) begin
                        state_d = SKP_BLK;
                    end else begin
                        state_d     = OS_BLK;
                        pend_type_d = classify_os(sym0);
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    wcnt_d  = 3'd0;
                end
            end else if (state_q == IDLE) begin
                wcnt_d = 3'd0;
            end else if (wcnt_q == 3'd0) begin
                // Block boundary expected but no start marker
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    DATA_BLK: begin
                        data_d       = word;
                        data_valid_d = 1'b1;
                        wcnt_d = (wcnt_q == 3'd3) ? 3'd0 : wcnt_q + 3'd1;
                    end
                    OS_BLK: begin
                        osbuf_d[{slot, 5'd0} +: 32] = word;
                        if (wcnt_q == 3'd3) begin
                            wcnt_d     = 3'd0;
                            os_valid_d = 1'b1;
                            os_type_d  = pend_type_q;
                            os_data_d  = osbuf_d;
                            skp_len_d  = 5'd0;
                        end else begin
                            wcnt_d = wcnt_q + 3'd1;
                        end
                    end
                    SKP_BLK: begin
                        if (wcnt_q < 3'd4) osbuf_d[{slot, 5'd0} +: 32] = word;
                        if (sym0 == GEN3_SKP_END) begin
                            wcnt_d     = 3'd0;
                            os_valid_d = 1'b1;
                            os_type_d  = OS_SKP;
                            os_data_d  = osbuf_d;
                            skp_len_d  = {wcnt_q + 3'd1, 2'b00};
                        end else if (wcnt_q == 3'd5) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            wcnt_d  = 3'd0;
                        end else begin
                            wcnt_d = wcnt_q + 3'd1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        wcnt_d  = 3'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wcnt_q       <= 3'd0;
            osbuf_q      <= '0;
            pend_type_q  <= OS_UNKNOWN;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            blk_start_q  <= 1'b0;
            os_valid_q   <= 1'b0;
            os_type_q    <= OS_UNKNOWN;
            os_data_q    <= '0;
            skp_len_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            osbuf_q      <= osbuf_d;
            pend_type_q  <= pend_type_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            blk_start_q  <= blk_start_d;
            os_valid_q   <= os_valid_d;
            os_type_q    <= os_type_d;
            os_data_q    <= os_data_d;
            skp_len_q    <= skp_len_d;
            err_q        <= err_d;
        end
    end

    assign data_o           = data_q;
    assign data_valid_o     = data_valid_q;
    assign data_blk_start_o = blk_start_q;
    assign os_valid_o       = os_valid_q;
    assign os_type_o        = os_type_q;
    assign os_data_o        = os_data_q;
    assign os_skp_len_o     = skp_len_q;
    assign block_err_o      = err_q;

endmodule

// File: tb/tb_rx_block_classifier.sv
// Directed bench for rx_block_classifier.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_rx_block_classifier;
    import pcie_phy_pkg::*;

    logic         clk;
    logic         rst;
    rate_speed_e  rate;
    logic [31:0]  data_o;
    logic         data_valid_o;
    logic         data_blk_start_o;
    logic         os_valid_o;
    os_type_e     os_type_o;
    logic [127:0] os_data_o;
    logic [4:0]   os_skp_len_o;
    logic         block_err_o;

    int n_chk;
    int n_fail;

    rx_block_classifier_if rx_if ();

    rx_block_classifier dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .curr_data_rate_i (rate),
        .rx               (rx_if.slave),
        .data_o           (data_o),
        .data_valid_o     (data_valid_o),
        .data_blk_start_o (data_blk_start_o),
        .os_valid_o       (os_valid_o),
        .os_type_o        (os_type_o),
        .os_data_o        (os_data_o),
        .os_skp_len_o     (os_skp_len_o),
        .block_err_o      (block_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [31:0] d, input logic bs, input logic [1:0] sh);
        rx_if.data_in_i     = d;
        rx_if.data_valid_i  = 1'b1;
        rx_if.block_start_i = bs;
        rx_if.sync_header_i = sh;
        @(negedge clk);
        rx_if.data_valid_i  = 1'b0;
        rx_if.block_start_i = 1'b0;
    endtask

    task automatic bubble();
        rx_if.data_valid_i  = 1'b0;
        rx_if.block_start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({data_o, data_valid_o, data_blk_start_o, os_valid_o, block_err_o} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %h/%b%b%b%b want 0", data_o, data_valid_o,
                     data_blk_start_o, os_valid_o, block_err_o);
        end
        n_chk++;
        if (os_type_o !== OS_UNKNOWN) begin
            n_fail++;
            $display("FAIL reset_type: got %0d want %0d", os_type_o, OS_UNKNOWN);
        end
        n_chk++;
        if ({os_data_o, os_skp_len_o} !== 133'd0) begin
            n_fail++;
            $display("FAIL reset_os: got %h len %0d want 0", os_data_o, os_skp_len_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ts1();
        logic [31:0] w [4];
        w[0] = 32'h4A4A_001E; w[1] = 32'h4A4A_4A4A;
        w[2] = 32'h4A4A_4A4A; w[3] = 32'h4545_4545;
        for (int i = 0; i < 4; i++) begin
            drive(w[i], i == 0, SYNC_OS);
            if (i < 3) begin
                n_chk++;
                if ({os_valid_o, block_err_o, data_valid_o} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL ts1_early%0d: got v%b e%b d%b want 000", i,
                             os_valid_o, block_err_o, data_valid_o);
                end
            end
        end
        n_chk++;
        if ({os_valid_o, block_err_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL ts1_valid: got v%b e%b want 10", os_valid_o, block_err_o);
        end
        n_chk++;
        if (os_type_o !== OS_TS1) begin
            n_fail++;
            $display("FAIL ts1_type: got %0d want %0d", os_type_o, OS_TS1);
        end
        n_chk++;
        if (os_data_o !== {w[3], w[2], w[1], w[0]} || os_data_o[7:0] !== 8'h1E) begin
            n_fail++;
            $display("FAIL ts1_data: got %h", os_data_o);
        end
        n_chk++;
        if (os_skp_len_o !== 5'd0) begin
            n_fail++;
            $display("FAIL ts1_len: got %0d want 0", os_skp_len_o);
        end
        bubble();
        n_chk++;
        if (os_valid_o !== 1'b0 || os_data_o !== {w[3], w[2], w[1], w[0]}) begin
            n_fail++;
            $display("FAIL ts1_pulse_hold: got v%b data %h", os_valid_o, os_data_o);
        end
    endtask

    task automatic test_data_blk();
        logic [31:0] w [4];
        w[0] = 32'hDEAD_BEEF; w[1] = 32'h0123_4567;
        w[2] = 32'h89AB_CDEF; w[3] = 32'h5A5A_A5A5;
        for (int i = 0; i < 4; i++) begin
            drive(w[i], i == 0, SYNC_DATA);
            n_chk++;
            if ({data_valid_o, data_blk_start_o} !== {1'b1, i == 0} || data_o !== w[i]) begin
                n_fail++;
                $display("FAIL data_w%0d: got v%b s%b %h want 1%b %h", i, data_valid_o,
                         data_blk_start_o, data_o, i == 0, w[i]);
            end
            if (i == 1) begin
                for (int j = 0; j < 2; j++) begin
                    bubble();
                    n_chk++;
                    if ({data_valid_o, data_blk_start_o, block_err_o} !== 3'b000) begin
                        n_fail++;
                        $display("FAIL data_stall%0d: got v%b s%b e%b want 000", j,
                                 data_valid_o, data_blk_start_o, block_err_o);
                    end
                end
            end
        end
        n_chk++;
        if (os_type_o !== OS_TS1 || os_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL data_os_hold: got type %0d v%b want %0d 0", os_type_o,
                     os_valid_o, OS_TS1);
        end
    endtask

    task automatic test_skp();
        drive(32'hAAAA_AAAA, 1'b1, SYNC_OS);
        drive(32'hAAAA_AAAA, 1'b0, SYNC_OS);
        n_chk++;
        if ({os_valid_o, block_err_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL skp_early: got v%b e%b want 00", os_valid_o, block_err_o);
        end
        drive(32'h0000_00E1, 1'b0, SYNC_OS);
        n_chk++;
        if (os_valid_o !== 1'b1 || os_type_o !== OS_SKP) begin
            n_fail++;
            $display("FAIL skp_valid: got v%b type %0d want 1 %0d", os_valid_o,
                     os_type_o, OS_SKP);
        end
        n_chk++;
        if (os_skp_len_o !== 5'd12) begin
            n_fail++;
            $display("FAIL skp_len: got %0d want 12", os_skp_len_o);
        end
        n_chk++;
        if (os_data_o !== {32'h0, 32'h0000_00E1, 32'hAAAA_AAAA, 32'hAAAA_AAAA}) begin
            n_fail++;
            $display("FAIL skp_data: got %h", os_data_o);
        end
        for (int i = 0; i < 6; i++) begin
            drive(32'hAAAA_AAAA, i == 0, SYNC_OS);
            n_chk++;
            if ({os_valid_o, block_err_o} !== {1'b0, i == 5}) begin
                n_fail++;
                $display("FAIL skp_long%0d: got v%b e%b want 0%b", i, os_valid_o,
                         block_err_o, i == 5);
            end
        end
        bubble();
        n_chk++;
        if (block_err_o !== 1'b0 || os_skp_len_o !== 5'd12) begin
            n_fail++;
            $display("FAIL skp_after: got e%b len %0d want 0 12", block_err_o, os_skp_len_o);
        end
    endtask

    task automatic test_bad_sync();
        drive(32'h0000_001E, 1'b1, 2'b11);
        n_chk++;
        if ({block_err_o, os_valid_o, data_valid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL badsync_err: got e%b v%b d%b want 100", block_err_o,
                     os_valid_o, data_valid_o);
        end
        drive(32'h1234_5678, 1'b0, SYNC_DATA);
        n_chk++;
        if ({block_err_o, data_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL badsync_idle_drop: got e%b d%b want 00", block_err_o, data_valid_o);
        end
        drive(32'h6666_6666, 1'b1, SYNC_OS);
        drive(32'h1111_1111, 1'b0, SYNC_OS);
        drive(32'h2222_2222, 1'b0, SYNC_OS);
        drive(32'h3333_3333, 1'b0, SYNC_OS);
        n_chk++;
        if (os_valid_o !== 1'b1 || os_type_o !== OS_EIOS || block_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL badsync_next: got v%b type %0d e%b want 1 %0d 0", os_valid_o,
                     os_type_o, block_err_o, OS_EIOS);
        end
    endtask

    task automatic test_missing_start();
        drive(32'h7777_7777, 1'b0, SYNC_DATA);
        n_chk++;
        if ({block_err_o, data_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL nostart_err: got e%b d%b want 10", block_err_o, data_valid_o);
        end
        drive(32'h7777_7777, 1'b0, SYNC_DATA);
        n_chk++;
        if ({block_err_o, data_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL nostart_idle: got e%b d%b want 00", block_err_o, data_valid_o);
        end
    endtask

    task automatic test_mid_block();
        drive(32'h2D2D_2D2D, 1'b1, SYNC_OS);
        drive(32'h0101_0101, 1'b0, SYNC_OS);
        drive(32'hCAFE_F00D, 1'b1, SYNC_DATA);
        n_chk++;
        if ({block_err_o, data_valid_o, data_blk_start_o, os_valid_o} !== 4'b1110 ||
            data_o !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL mid_restart: got e%b d%b s%b v%b %h want 1110 cafef00d",
                     block_err_o, data_valid_o, data_blk_start_o, os_valid_o, data_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(32'h1000_0000 + i, 1'b0, SYNC_DATA);
            n_chk++;
            if ({block_err_o, data_valid_o, data_blk_start_o, os_valid_o} !== 4'b0100 ||
                data_o !== 32'h1000_0000 + i) begin
                n_fail++;
                $display("FAIL mid_data%0d: got e%b d%b s%b v%b %h", i, block_err_o,
                         data_valid_o, data_blk_start_o, os_valid_o, data_o);
            end
        end
        n_chk++;
        if (os_type_o !== OS_EIOS) begin
            n_fail++;
            $display("FAIL mid_no_ts2: got type %0d want %0d", os_type_o, OS_EIOS);
        end
    endtask

    task automatic test_reset_mid();
        drive(32'hE1E1_E1E1, 1'b1, SYNC_OS);
        drive(32'h0202_0202, 1'b0, SYNC_OS);
        rst = 1'b1;
        #1;
        n_chk++;
        if ({data_o, data_valid_o, data_blk_start_o, os_valid_o, block_err_o,
             os_skp_len_o} !== 41'd0 || os_type_o !== OS_UNKNOWN || os_data_o !== 128'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got d%b v%b e%b type %0d data %h", data_valid_o,
                     os_valid_o, block_err_o, os_type_o, os_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0303_0303, 1'b0, SYNC_OS);
        drive(32'h0404_0404, 1'b0, SYNC_OS);
        n_chk++;
        if ({os_valid_o, block_err_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_partial: got v%b e%b want 00", os_valid_o, block_err_o);
        end
        drive(32'hFF00_FF00, 1'b1, SYNC_OS);
        drive(32'h0505_0505, 1'b0, SYNC_OS);
        drive(32'h0606_0606, 1'b0, SYNC_OS);
        drive(32'h0707_0707, 1'b0, SYNC_OS);
        n_chk++;
        if (os_valid_o !== 1'b1 || os_type_o !== OS_EIEOS ||
            os_data_o !== {32'h0707_0707, 32'h0606_0606, 32'h0505_0505, 32'hFF00_FF00}) begin
            n_fail++;
            $display("FAIL rstmid_eieos: got v%b type %0d data %h", os_valid_o,
                     os_type_o, os_data_o);
        end
    endtask

    task automatic test_gen2();
        rate = RATE_GEN2;
        drive(32'h0000_001E, 1'b1, SYNC_OS);
        drive(32'h1111_1111, 1'b0, SYNC_OS);
        drive(32'h2222_2222, 1'b0, SYNC_OS);
        drive(32'h3333_3333, 1'b0, SYNC_OS);
        n_chk++;
        if ({os_valid_o, block_err_o, data_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL gen2_os: got v%b e%b d%b want 000", os_valid_o,
                     block_err_o, data_valid_o);
        end
        drive(32'h4444_4444, 1'b1, 2'b00);
        drive(32'h5555_5555, 1'b1, SYNC_DATA);
        n_chk++;
        if ({os_valid_o, block_err_o, data_valid_o, data_blk_start_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL gen2_data: got v%b e%b d%b s%b want 0000", os_valid_o,
                     block_err_o, data_valid_o, data_blk_start_o);
        end
        rate = RATE_GEN3;
        drive(32'h0000_0055, 1'b1, SYNC_OS);
        drive(32'h0808_0808, 1'b0, SYNC_OS);
        drive(32'h0909_0909, 1'b0, SYNC_OS);
        drive(32'h0A0A_0A0A, 1'b0, SYNC_OS);
        n_chk++;
        if (os_valid_o !== 1'b1 || os_type_o !== OS_UNKNOWN || block_err_o !== 1'b0 ||
            os_skp_len_o !== 5'd0) begin
            n_fail++;
            $display("FAIL gen3_unknown: got v%b type %0d e%b len %0d", os_valid_o,
                     os_type_o, block_err_o, os_skp_len_o);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rate = RATE_GEN3;
        rx_if.data_in_i     = '0;
        rx_if.data_valid_i  = 1'b0;
        rx_if.block_start_i = 1'b0;
        rx_if.sync_header_i = 2'b00;
        test_reset();
        test_ts1();
        test_data_blk();
        test_skp();
        test_bad_sync();
        test_missing_start();
        test_mid_block();
        test_reset_mid();
        test_gen2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
